// File: rtl/ring_evt_xfer.sv
// rtl/ring_evt_xfer.sv - sample ring buffer with L1A event queue and lookback readout
module ring_evt_xfer #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 12,
  parameter int L1A_AW   = 4,
  parameter int TAG_W    = 24,
  parameter int SAMP_W   = 7,
  parameter int WARN_LVL = 3328
) (
  input  logic              CLK,
  input  logic              RST_RESYNC,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WREN,
  input  logic [ADDR_W-1:0] PRETRIG,
  input  logic              L1A_PUSH,
  input  logic [TAG_W-1:0]  L1A_TAG,
  input  logic [SAMP_W-1:0] SAMP_MAX,
  input  logic              EVT_BUF_AFL,
  output logic [DATA_W-1:0] RDATA,
  output logic              DATA_PUSH,
  output logic [TAG_W-1:0]  L1A_EVT_DATA,
  output logic              L1A_EVT_PUSH,
  output logic [ADDR_W:0]   OCC,
  output logic              WARN,
  output logic              OVFL,
  output logic              L1A_DROP
);

  localparam int PW = ADDR_W + 1;
  localparam int RING_D = 1 << ADDR_W;
  localparam int Q_D = 1 << L1A_AW;
  localparam logic [PW-1:0] OCC_FULL = PW'(RING_D);
  localparam logic [PW-1:0] WARN_C = PW'(WARN_LVL);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  // Ring storage and the L1A queue storage carry no reset.
  logic [DATA_W-1:0] mem [0:RING_D-1];
  logic [DATA_W-1:0] ram_q;
  logic [TAG_W-1:0]  lq_tag [0:Q_D-1];
  logic [PW-1:0]     lq_start [0:Q_D-1];

  state_t            state_q, state_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [SAMP_W-1:0] cnt_q, cnt_d;
  logic [L1A_AW:0]   qwr_q, qwr_d;
  logic [L1A_AW:0]   qrd_q, qrd_d;
  logic              v1_q, v1_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              evt_push_q, evt_push_d;
  logic [PW-1:0]     occ_q, occ_d;
  logic              warn_q, warn_d;
  logic              ovfl_q, ovfl_d;
  logic              drop_q, drop_d;

  logic              q_empty, q_full, q_push, q_pop, issue, pp_vld;
  logic [PW-1:0]     pp, head_start, q_start_in;
  logic [TAG_W-1:0]  head_tag;

  assign q_empty    = (qwr_q == qrd_q);
  assign q_full     = (qwr_q[L1A_AW] != qrd_q[L1A_AW]) &&
                      (qwr_q[L1A_AW-1:0] == qrd_q[L1A_AW-1:0]);
  assign head_start = lq_start[qrd_q[L1A_AW-1:0]];
  assign head_tag   = lq_tag[qrd_q[L1A_AW-1:0]];
  // Event start uses the write pointer before any same-cycle increment.
  assign q_start_in = wp_q - {1'b0, PRETRIG};

  // Next-state: pointers, queue, transfer FSM, read pipeline and status.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    qwr_d      = qwr_q;
    qrd_d      = qrd_q;
    tag_d      = tag_q;
    evt_push_d = 1'b0;
    issue      = 1'b0;
    q_pop      = 1'b0;
    q_push     = 1'b0;
    pp         = '0;
    pp_vld     = 1'b0;

    if (WREN) wp_d = wp_q + PW'(1);

    case (state_q)
      IDLE: begin
        if (!q_empty && !EVT_BUF_AFL) state_d = LOAD;
      end
      LOAD: begin
        q_pop      = 1'b1;
        rd_ptr_d   = head_start;
        tag_d      = head_tag;
        evt_push_d = 1'b1;
        cnt_d      = SAMP_MAX;
        state_d    = (SAMP_MAX == '0) ? IDLE : READ;
      end
      READ: begin
        // rd_ptr == wp means the post-trigger word is not written yet.
        if (!EVT_BUF_AFL && (rd_ptr_q != wp_q)) begin
          issue    = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          cnt_d    = cnt_q - SAMP_W'(1);
          if (cnt_q == SAMP_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop frees the slot, so a push into a full queue still succeeds.
    q_push = L1A_PUSH && (!q_full || q_pop);
    if (q_push) qwr_d = qwr_q + (L1A_AW+1)'(1);
    if (q_pop)  qrd_d = qrd_q + (L1A_AW+1)'(1);
    drop_d = L1A_PUSH && q_full && !q_pop;

    // In LOAD the head being popped is exactly the start rd_ptr takes next.
    if (state_q == READ) begin
      pp     = rd_ptr_q;
      pp_vld = 1'b1;
    end else if (!q_empty) begin
      pp     = head_start;
      pp_vld = 1'b1;
    end
    occ_d  = pp_vld ? (wp_q - pp) : '0;
    warn_d = (occ_d > WARN_C);
    ovfl_d = ovfl_q | (WREN && (occ_d == OCC_FULL));

    v1_d    = issue;
    push_d  = v1_q;
    rdata_d = v1_q ? ram_q : rdata_q;
  end

  // Ring write port and registered read port (first stage of the read pipe).
  always_ff @(posedge CLK) begin
    if (WREN)  mem[wp_q[ADDR_W-1:0]] <= WDATA;
    if (issue) ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  // L1A queue entry storage.
  always_ff @(posedge CLK) begin
    if (q_push) begin
      lq_tag[qwr_q[L1A_AW-1:0]]   <= L1A_TAG;
      lq_start[qwr_q[L1A_AW-1:0]] <= q_start_in;
    end
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge CLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      qwr_q      <= '0;
      qrd_q      <= '0;
      v1_q       <= 1'b0;
      push_q     <= 1'b0;
      rdata_q    <= '0;
      tag_q      <= '0;
      evt_push_q <= 1'b0;
      occ_q      <= '0;
      warn_q     <= 1'b0;
      ovfl_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      qwr_q      <= qwr_d;
      qrd_q      <= qrd_d;
      v1_q       <= v1_d;
      push_q     <= push_d;
      rdata_q    <= rdata_d;
      tag_q      <= tag_d;
      evt_push_q <= evt_push_d;
      occ_q      <= occ_d;
      warn_q     <= warn_d;
      ovfl_q     <= ovfl_d;
      drop_q     <= drop_d;
    end
  end

  assign RDATA        = rdata_q;
  assign DATA_PUSH    = push_q;
  assign L1A_EVT_DATA = tag_q;
  assign L1A_EVT_PUSH = evt_push_q;
  assign OCC          = occ_q;
  assign WARN         = warn_q;
  assign OVFL         = ovfl_q;
  assign L1A_DROP     = drop_q;

endmodule

// File: tb/tb_ring_evt_xfer.sv
// tb/tb_ring_evt_xfer.sv - scoreboard bench for ring_evt_xfer
module tb_ring_evt_xfer;
  localparam int DW = 12, AW = 4, QAW = 2, TW = 24, SW = 7, WL = 12;

  logic          clk = 0, rst = 0;
  logic [DW-1:0] wdata = 0;
  logic          wren = 0, l1a_push = 0, afl = 0;
  logic [AW-1:0] pretrig = 0;
  logic [TW-1:0] l1a_tag = 0;
  logic [SW-1:0] samp_max = 0;
  logic [DW-1:0] rdata;
  logic          data_push, evt_push, warn, ovfl, drop;
  logic [TW-1:0] evt_data;
  logic [AW:0]   occ;

  int n_cmp = 0, n_bad = 0;
  int hist[$];     // every word written, indexed by absolute write number
  int exp_idx[$];  // absolute write numbers expected on DATA_PUSH, in order
  int exp_tag[$];  // tags expected on L1A_EVT_PUSH, in order
  int drop_cnt = 0;
  int base = 0;

  ring_evt_xfer #(.DATA_W(DW), .ADDR_W(AW), .L1A_AW(QAW), .TAG_W(TW), .SAMP_W(SW), .WARN_LVL(WL)) dut (
    .CLK(clk), .RST_RESYNC(rst), .WDATA(wdata), .WREN(wren), .PRETRIG(pretrig),
    .L1A_PUSH(l1a_push), .L1A_TAG(l1a_tag), .SAMP_MAX(samp_max), .EVT_BUF_AFL(afl),
    .RDATA(rdata), .DATA_PUSH(data_push), .L1A_EVT_DATA(evt_data), .L1A_EVT_PUSH(evt_push),
    .OCC(occ), .WARN(warn), .OVFL(ovfl), .L1A_DROP(drop));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_push) begin
        if (exp_idx.size() == 0) chk("unexpected_data_push", 1, 0);
        else begin
          int idx;
          idx = exp_idx.pop_front();
          chk("word_written_before_read", int'(idx < hist.size()), 1);
          if (idx < hist.size()) chk("rdata", int'(rdata), hist[idx]);
        end
      end
      if (evt_push) begin
        if (exp_tag.size() == 0) chk("unexpected_evt_push", 1, 0);
        else chk("evt_tag", int'(evt_data), exp_tag.pop_front());
      end
      if (drop) drop_cnt++;
    end
  end

  task automatic step(input bit we, input bit push, input int wval);
    wren = we; wdata = wval[DW-1:0]; l1a_push = push;
    @(posedge clk); #1;
    if (we) hist.push_back(wval & 32'hFFF);
    wren = 0; l1a_push = 0;
  endtask

  task automatic do_reset();
    rst = 1; wren = 0; l1a_push = 0; afl = 0;
    exp_idx.delete(); exp_tag.delete(); drop_cnt = 0;
    // After reset wp restarts at 0, so realign absolute numbering to a wp wrap.
    while (hist.size() % 32 != 0) hist.push_back(-1);
    base = hist.size();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run_until_drained(input int wmode, input int afl_pct, input int budget);
    int c, est;
    bit we;
    c = 0;
    while (c < budget && (exp_idx.size() != 0 || exp_tag.size() != 0)) begin
      est = (exp_idx.size() != 0) ? hist.size() - exp_idx[0] : 0;
      we = (wmode == 1) ? (c % 3 == 2) : ($urandom_range(0, 1) == 1);
      if (est >= 12) we = 0;
      afl = ($urandom_range(0, 99) < afl_pct);
      step(we, 0, $urandom_range(0, 4095));
      c++;
    end
    afl = 0;
    chk("drain_outstanding", exp_idx.size() + exp_tag.size(), 0);
    exp_idx.delete(); exp_tag.delete();
    repeat (4) step(0, 0, 0);
  endtask

  task automatic do_event(input int tag, input int pt, input int sm, input bit we,
                          input int wmode, input int afl_pct);
    int st;
    pretrig = pt[AW-1:0]; l1a_tag = tag[TW-1:0]; samp_max = sm[SW-1:0];
    st = hist.size() - pt;
    exp_tag.push_back(tag);
    for (int i = 0; i < sm; i++) exp_idx.push_back(st + i);
    step(we, 1, $urandom_range(0, 4095));
    run_until_drained(wmode, afl_pct, 400);
    chk("evt_tag_held", int'(evt_data), tag);
  endtask

  initial begin
    int st0, pt, lim;
    #1;
    do_reset();
    // Reset state
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_data_push", int'(data_push), 0);
    chk("rst_evt_data", int'(evt_data), 0);
    chk("rst_evt_push", int'(evt_push), 0);
    chk("rst_occ", int'(occ), 0);
    chk("rst_warn", int'(warn), 0);
    chk("rst_ovfl", int'(ovfl), 0);
    chk("rst_drop", int'(drop), 0);

    // Lookback readout: 1..10 written, PRETRIG 4, 3 samples -> 7,8,9
    for (int i = 1; i <= 10; i++) step(1, 0, i);
    step(0, 0, 0);
    chk("occ_no_event", int'(occ), 0);
    do_event(5, 4, 3, 0, 0, 0);

    // Post-trigger reads stall on unwritten words
    do_event(7, 0, 4, 0, 1, 0);

    // Queue full: 5 pushes with AFL held, one dropped
    afl = 1; samp_max = 0; pretrig = 0;
    st0 = hist.size();
    for (int i = 0; i < 5; i++) begin
      l1a_tag = TW'(32'h11 + i);
      if (i < 4) exp_tag.push_back(32'h11 + i);
      step(1, 1, $urandom_range(0, 4095));
    end
    step(0, 0, 0); step(0, 0, 0);
    chk("l1a_drop_pulses", drop_cnt, 1);
    chk("occ_queued_head", int'(occ), hist.size() - st0);
    chk("warn_low", int'(warn), 0);
    afl = 0;
    step(0, 0, 0);
    l1a_tag = TW'(32'h16);
    exp_tag.push_back(32'h16);
    step(0, 1, 0);  // lands in the pop cycle with the queue full
    run_until_drained(0, 0, 100);
    chk("l1a_drop_after_pushpop", drop_cnt, 1);

    // Occupancy, warning and sticky overflow
    do_reset();
    step(1, 0, $urandom_range(0, 4095));
    step(1, 0, $urandom_range(0, 4095));
    afl = 1; pretrig = 0; samp_max = 1; l1a_tag = TW'(32'h44);
    step(0, 1, 0);
    for (int k = 1; k <= 17; k++) begin
      step(1, 0, $urandom_range(0, 4095));
      step(0, 0, 0);
      chk($sformatf("occ_after_%0d_writes", k), int'(occ), k);
      chk($sformatf("warn_after_%0d_writes", k), int'(warn), int'(k > WL));
      chk($sformatf("ovfl_after_%0d_writes", k), int'(ovfl), int'(k >= 17));
    end
    repeat (3) step(0, 0, 0);
    chk("ovfl_sticky", int'(ovfl), 1);
    do_reset();
    chk("ovfl_cleared_by_reset", int'(ovfl), 0);
    chk("occ_cleared_by_reset", int'(occ), 0);

    // Wrap of write pointer and ring index during an event, AFL toggling
    for (int i = 0; i < 28; i++) step(1, 0, $urandom_range(0, 4095));
    do_event(32'h55, 4, 12, 1, 0, 40);

    // Randomized events
    for (int e = 0; e < 12; e++) begin
      lim = hist.size() - base;
      if (lim > 4) lim = 4;
      pt = $urandom_range(0, lim);
      do_event($urandom_range(0, 24'hFFFFFF), pt, $urandom_range(0, 6),
               $urandom_range(0, 1) == 1, 0, $urandom_range(0, 50));
    end

    // Reset during READ drops the event
    for (int i = 0; i < 6; i++) step(1, 0, $urandom_range(0, 4095));
    pretrig = 4; samp_max = 10; l1a_tag = TW'(32'h77);
    st0 = hist.size() - 4;
    exp_tag.push_back(32'h77);
    for (int i = 0; i < 10; i++) exp_idx.push_back(st0 + i);
    step(0, 1, 0);
    begin
      int c;
      c = 0;
      while (c < 100 && exp_idx.size() > 7) begin
        step(1, 0, $urandom_range(0, 4095));
        c++;
      end
      chk("reach_mid_read", int'(exp_idx.size() <= 7), 1);
    end
    rst = 1;
    #1 chk("data_push_at_reset", int'(data_push), 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("data_push_after_reset", int'(data_push), 0);
      chk("occ_after_reset", int'(occ), 0);
    end
    for (int i = 0; i < 6; i++) step(1, 0, $urandom_range(0, 4095));
    do_event(32'h78, 3, 5, 0, 0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
